// File: rtl/mvb_deser_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mvb_deser_pkg
//  Brief    : Shared defaults, width helper and FIFO entry type for the MVB
//             receive-path word deserializer.
//  Revision : 1.0 - initial release
// ============================================================================
package mvb_deser_pkg;

   // Default configuration of the deserializer
   localparam int DEFAULT_WORD_W     = 16;
   localparam int DEFAULT_FIFO_DEPTH = 4;
   localparam int DEFAULT_MSB_FIRST  = 1;

   // Widest word the FIFO entry type can carry
   localparam int MAX_WORD_W = 32;

   // Width needed to hold a bit count in the range 0..w
   function automatic int word_bits_w(input int w);
      return $clog2(w + 1);
   endfunction

   localparam int MAX_BITS_W = word_bits_w(MAX_WORD_W);

   // One FIFO entry: assembled word plus its number of valid bits.
   // Narrower configurations use the low-order slice of each field.
   typedef struct packed {
      logic [MAX_WORD_W-1:0] data;
      logic [MAX_BITS_W-1:0] bits;
   } mvb_word_t;

endpackage
`default_nettype wire

// File: rtl/mvb_word_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : mvb_word_fifo
//  Brief    : Synchronous FIFO with a registered show-ahead head. Pointers
//             carry one extra wrap bit to tell full from empty. A write
//             while full is accepted only when a read happens in the same
//             cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module mvb_word_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk_3M,
   input  logic                       rst,
   input  logic                       i_wr_en,
   input  logic [WIDTH-1:0]           i_wr_data,
   input  logic                       i_rd_en,
   output logic [WIDTH-1:0]           o_rd_data,
   output logic                       o_empty,
   output logic                       o_full,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int c_aw = $clog2(DEPTH);
   localparam int c_pw = c_aw + 1;
   localparam int c_cw = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_pw-1:0]  r_wr_ptr;
   logic [c_pw-1:0]  r_rd_ptr;
   logic [c_cw-1:0]  r_count;
   logic [WIDTH-1:0] r_head;

   logic             w_push;
   logic             w_pop;
   logic [c_pw-1:0]  w_rd_ptr_nxt;
   logic [c_cw-1:0]  w_count_nxt;
   logic [WIDTH-1:0] w_head_nxt;

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                    (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);

   assign w_pop        = i_rd_en && !o_empty;
   assign w_push       = i_wr_en && (!o_full || w_pop);
   assign w_rd_ptr_nxt = r_rd_ptr + c_pw'(w_pop);

   assign o_rd_data = r_head;
   assign o_count   = r_count;

   // Occupancy after this cycle's push/pop
   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + c_cw'(1);
      end else if (!w_push && w_pop) begin
         w_count_nxt = r_count - c_cw'(1);
      end
   end

   // Next head: bypass the incoming word when it lands in the head slot
   always_comb begin
      w_head_nxt = r_head;
      if (w_count_nxt == '0) begin
         w_head_nxt = '0;
      end else if (w_push && (r_wr_ptr[c_aw-1:0] == w_rd_ptr_nxt[c_aw-1:0])) begin
         w_head_nxt = i_wr_data;
      end else begin
         w_head_nxt = r_mem[w_rd_ptr_nxt[c_aw-1:0]];
      end
   end

   // Storage array, written on accepted pushes only
   always_ff @(posedge clk_3M) begin
      if (w_push) begin
         r_mem[r_wr_ptr[c_aw-1:0]] <= i_wr_data;
      end
   end

   // Pointers, occupancy and registered head
   always_ff @(posedge clk_3M or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_head   <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_pw'(1);
         end
         r_rd_ptr <= w_rd_ptr_nxt;
         r_count  <= w_count_nxt;
         r_head   <= w_head_nxt;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mvb_word_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : mvb_word_deserializer
//  Brief    : MVB receive-path serial-to-parallel converter. Samples one bit
//             per clk_3M cycle, assembles WORD_W-bit words MSB- or LSB-first,
//             flushes a zero-padded partial word on frame_end and queues the
//             words in a valid/ready output FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module mvb_word_deserializer
   import mvb_deser_pkg::*;
#(
   parameter int WORD_W     = DEFAULT_WORD_W,
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
   parameter int MSB_FIRST  = DEFAULT_MSB_FIRST
) (
   input  logic                            clk_3M,
   input  logic                            rst,
   input  logic                            deserializer_wait,
   input  logic                            data_in,
   input  logic                            frame_end,
   input  logic                            word_ready,
   output logic                            word_valid,
   output logic [WORD_W-1:0]               word_data,
   output logic [word_bits_w(WORD_W)-1:0]  word_bits,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fill_level,
   output logic                            overflow
);

   localparam int              c_bw       = word_bits_w(WORD_W);
   localparam int              c_fw       = $bits(mvb_word_t);
   localparam logic [c_bw-1:0] c_full_cnt = c_bw'(WORD_W);

   logic [WORD_W-1:0] r_shift;
   logic [c_bw-1:0]   r_cnt;
   logic              r_overflow;

   logic [WORD_W-1:0] w_shift_nxt;
   logic [c_bw-1:0]   w_cnt_inc;
   logic              w_word_done;
   logic              w_flush;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   mvb_word_t         w_entry;
   mvb_word_t         w_head;

   // Each shift-register bit captures data_in at the one count value that
   // addresses it; all other bits hold. Unfilled positions stay zero because
   // the register is cleared at every word boundary.
   for (genvar i = 0; i < WORD_W; i++) begin : g_bit
      localparam int c_pos = (MSB_FIRST != 0) ? (WORD_W - 1 - i) : i;
      assign w_shift_nxt[i] = (r_cnt == c_bw'(c_pos)) ? data_in : r_shift[i];
   end

   // The sample taken this cycle is always counted, so a flush never
   // produces an empty word.
   assign w_cnt_inc   = r_cnt + c_bw'(1);
   assign w_word_done = !deserializer_wait && (w_cnt_inc == c_full_cnt);
   assign w_flush     = !deserializer_wait && frame_end;
   assign w_push      = w_word_done || w_flush;
   assign w_pop       = word_valid && word_ready;

   // FIFO entry built from the word including this cycle's bit
   always_comb begin
      w_entry                   = '0;
      w_entry.data[WORD_W-1:0]  = w_shift_nxt;
      w_entry.bits[c_bw-1:0]    = w_cnt_inc;
   end

   // Bit assembly: clear on wait or on any push, otherwise accumulate
   always_ff @(posedge clk_3M or negedge rst) begin
      if (!rst) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (deserializer_wait || w_push) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else begin
         r_shift <= w_shift_nxt;
         r_cnt   <= w_cnt_inc;
      end
   end

   // Overflow pulse: a push that the full FIFO cannot take this cycle
   always_ff @(posedge clk_3M or negedge rst) begin
      if (!rst) begin
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= w_push && w_full && !w_pop;
      end
   end

   mvb_word_fifo #(
      .WIDTH (c_fw),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_3M    (clk_3M),
      .rst       (rst),
      .i_wr_en   (w_push),
      .i_wr_data (w_entry),
      .i_rd_en   (word_ready),
      .o_rd_data (w_head),
      .o_empty   (w_empty),
      .o_full    (w_full),
      .o_count   (fill_level)
   );

   assign word_valid = !w_empty;
   assign word_data  = w_head.data[WORD_W-1:0];
   assign word_bits  = w_head.bits[c_bw-1:0];
   assign overflow   = r_overflow;

endmodule
`default_nettype wire
